// File: rtl/seven_seg_scanner.sv
// Seven-segment scan controller.
// Steps through NUM_DIGITS digits, one slot of DIV clocks each. The first GUARD
// clocks of every slot are dark to stop ghosting. Digits above the most
// significant non-zero or decimal-point digit can be blanked. New values go into
// a shadow register and move to the active register only at a frame wrap, so a
// frame is never shown half old and half new.
module seven_seg_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int DIV           = 50000,
    parameter int GUARD         = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask_in,
    input  logic                    value_valid,
    input  logic                    display_en,
    output logic [3:0]              digit_nibble,
    output logic                    digit_en,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]             cnt;
    logic [IDX_W-1:0]             idx;
    logic                         slot_end;
    logic                         wrap;
    logic                         lit;

    logic [NUM_DIGITS-1:0][3:0]   shadow_val;
    logic [NUM_DIGITS-1:0][3:0]   active_val;
    logic [NUM_DIGITS-1:0]        shadow_dp;
    logic [NUM_DIGITS-1:0]        active_dp;

    // quiet_above[i]: digits i..NUM_DIGITS-1 all hold zero and none asks for a
    // decimal point. A digit below a dp digit therefore stays visible.
    logic [NUM_DIGITS:1]          quiet_above;
    logic [NUM_DIGITS-1:0]        blank;

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);
    assign lit      = display_en && (cnt >= CNT_GUARD);

    assign quiet_above[NUM_DIGITS] = 1'b1;
    assign blank[0]                = 1'b0;

    generate
        for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_blank
            assign quiet_above[i] = quiet_above[i+1] && (active_val[i] == 4'h0) && !active_dp[i];
            assign blank[i]       = (BLANK_LEADING != 0) && quiet_above[i];
        end
    endgenerate

    // Slot prescaler and digit index. Wrap at NUM_DIGITS is explicit so any digit count works.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow register: the last strobe before a wrap is the one that gets shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (value_valid) begin
            shadow_val <= value_in;
            shadow_dp  <= dp_mask_in;
        end
    end

    // Active register changes only at a frame wrap. A strobe in the wrap cycle
    // lands in the shadow and waits one more frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_val <= '0;
            active_dp  <= '0;
        end else if (wrap) begin
            active_val <= shadow_val;
            active_dp  <= shadow_dp;
        end
    end

    // Registered decoder and common-line drive, one cycle behind (cnt, idx).
    // A blanked digit keeps its select so all slots have the same duty cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_nibble <= '0;
            digit_en     <= 1'b0;
            dp           <= 1'b0;
            digit_sel    <= '0;
            frame_done   <= 1'b0;
        end else begin
            digit_nibble <= active_val[idx];
            frame_done   <= wrap;
            if (lit) begin
                digit_sel <= NUM_DIGITS'(1) << idx;
                digit_en  <= !blank[idx];
                dp        <= active_dp[idx] && !blank[idx];
            end else begin
                digit_sel <= '0;
                digit_en  <= 1'b0;
                dp        <= 1'b0;
            end
        end
    end

endmodule
